// File: rtl/receive_state_machine_pkg.sv
// Shared types and helpers for the eUSCI_A UART receiver: state encodings,
// shadowed frame format and the data-bit shift helper.
package receive_state_machine_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  typedef struct packed {
    logic pen;
    logic par;
    logic msb;
    logic b7;
    logic spb;
  } rx_cfg_t;

  // LSB-first fills from the top of the 7/8-bit field; MSB-first fills from bit 0.
  function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b,
                                          input logic msb, input logic b7);
    logic [7:0] r;
    if (msb)     r = {sr[6:0], b};
    else if (b7) r = {1'b0, b, sr[6:1]};
    else         r = {b, sr[7:1]};
    if (b7) r[7] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/receive_state_machine_rx_bit_sampler.sv
// Rx synchronizer, per-bit tick counter and bit decision for the UART receiver.
// UART_RX_MAJORITY_EN selects 2-of-3 voting around the bit centre.
module rx_bit_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic BITCLK,
  input  logic reset,
  input  logic Rx,
  input  logic restart,
  input  logic active,
  output logic fall,
  output logic bit_val,
  output logic bit_valid
);

  localparam int C  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);

  logic          s1, s2, prev;
  logic [TW-1:0] tick;

  // tick tracks (cycles since the start edge) mod OVERSAMPLE, so the edge cycle is tick 0
  always_ff @(posedge BITCLK) begin
    if (!reset) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
      tick <= '0;
    end else begin
      s1   <= Rx;
      s2   <= s1;
      prev <= s2;
      if (restart)     tick <= TW'(1);
      else if (active) tick <= (tick == TW'(OVERSAMPLE - 1)) ? '0 : tick + 1'b1;
      else             tick <= '0;
    end
  end

  assign fall = prev & ~s2;

`ifdef UART_RX_MAJORITY_EN
  logic samp_a, samp_b;

  always_ff @(posedge BITCLK) begin
    if (!reset) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else begin
      if (tick == TW'(C - 1)) samp_a <= s2;
      if (tick == TW'(C))     samp_b <= s2;
    end
  end

  assign bit_val   = (samp_a & samp_b) | (samp_a & s2) | (samp_b & s2);
  assign bit_valid = active && (tick == TW'(C + 1));
`else
  assign bit_val   = s2;
  assign bit_valid = active && (tick == TW'(C));
`endif

endmodule

// File: rtl/receive_state_machine.sv
// eUSCI_A UART receive FSM: frames one character from Rx and emits the buffer
// write strobe plus flag pulses. Build option: UART_RX_MAJORITY_EN (see sampler).
module receive_state_machine
  import receive_state_machine_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       BITCLK,
  input  logic       reset,
  input  logic       wUCPEN,
  input  logic       wUCPAR,
  input  logic       wUCMSB,
  input  logic       wUC7BIT,
  input  logic       wUCSPB,
  input  logic       Rx,
  input  logic       RxBufFull,
  output logic [7:0] RxData,
  output logic       RxBufWrite,
  output logic       setRXIFG,
  output logic       setUCFE,
  output logic       setUCPE,
  output logic       setUCOE,
  output logic       setUCBRK,
  output logic       RxBusy
);

  rx_state_t  state, state_nxt;
  rx_cfg_t    cfg;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       par_acc, pe, any_one;
  logic       fall, bit_val, bit_valid, start_det, last_bit;
  logic       unused_spb;

  assign start_det = (state == IDLE) && fall;
  assign last_bit  = bit_cnt == (cfg.b7 ? 3'd6 : 3'd7);

  rx_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .BITCLK    (BITCLK),
    .reset     (reset),
    .Rx        (Rx),
    .restart   (start_det),
    .active    (state != IDLE),
    .fall      (fall),
    .bit_val   (bit_val),
    .bit_valid (bit_valid)
  );

  always_ff @(posedge BITCLK) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge BITCLK) begin
    if (!reset) begin
      cfg     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      pe      <= 1'b0;
      any_one <= 1'b0;
    end else if (start_det) begin
      cfg     <= '{pen: wUCPEN, par: wUCPAR, msb: wUCMSB, b7: wUC7BIT, spb: wUCSPB};
      bit_cnt <= '0;
      par_acc <= 1'b0;
      pe      <= 1'b0;
      any_one <= 1'b0;
    end else if (bit_valid) begin
      case (state)
        DATA: begin
          shreg   <= shift_in(shreg, bit_val, cfg.msb, cfg.b7);
          bit_cnt <= bit_cnt + 3'd1;
          par_acc <= par_acc ^ bit_val;
          any_one <= any_one | bit_val;
        end
        PARITY: begin
          // expected parity bit: data XOR for even sense, its complement for odd
          pe      <= bit_val != (par_acc ^ ~cfg.par);
          any_one <= any_one | bit_val;
        end
        default: ;
      endcase
    end
  end

  // Second stop bit only matters to the transmitter; reception ends after the first.
  assign unused_spb = cfg.spb;

  always_comb begin
    state_nxt  = state;
    RxBufWrite = 1'b0;
    setRXIFG   = 1'b0;
    setUCFE    = 1'b0;
    setUCPE    = 1'b0;
    setUCOE    = 1'b0;
    setUCBRK   = 1'b0;
    case (state)
      IDLE:   if (fall) state_nxt = START;
      START:  if (bit_valid) state_nxt = bit_val ? IDLE : DATA;
      DATA:   if (bit_valid && last_bit) state_nxt = cfg.pen ? PARITY : STOP;
      PARITY: if (bit_valid) state_nxt = STOP;
      STOP: begin
        if (bit_valid) begin
          state_nxt  = IDLE;
          RxBufWrite = reset;
          setRXIFG   = reset;
          setUCFE    = reset & ~bit_val;
          setUCPE    = reset & pe;
          setUCOE    = reset & RxBufFull;
          setUCBRK   = reset & ~any_one & ~bit_val;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign RxBusy = state != IDLE;
  assign RxData = shreg;

endmodule

// File: doc/receive_state_machine.md
# receive_state_machine

UART receive state machine for the eUSCI_A block. It recovers one asynchronous frame from the Rx pin, checks parity and the stop bit, and delivers the assembled character to the receive buffer as a one-cycle write strobe with interrupt-flag set pulses. It is the receive-side counterpart of TransmitStateMachine, uses the same frame-format controls (parity enable, parity sense, MSB-first, 7-bit, stop bits), and is driven by a clock running at OVERSAMPLE × baud.

## Interface
- OVERSAMPLE, 16, BITCLK cycles per bit; even, ≥ 4.
- BITCLK  in  1  sample clock, OVERSAMPLE × baud; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- wUCPEN  in  1  parity enable.
- wUCPAR  in  1  parity sense: 0 = odd, 1 = even.
- wUCMSB  in  1  1 = MSB first.
- wUC7BIT  in  1  1 = 7 data bits.
- wUCSPB  in  1  1 = two stop bits.
- Rx  in  1  asynchronous serial input; idles high.
- RxBufFull  in  1  receive buffer unread (UCRXIFG currently set).
- RxData  out  8  assembled character; in 7-bit mode it is right-justified with bit 7 = 0.
- RxBufWrite  out  1  one-cycle strobe; RxData is valid on this cycle.
- setRXIFG  out  1  one-cycle pulse, coincident with RxBufWrite.
- setUCFE  out  1  framing-error pulse.
- setUCPE  out  1  parity-error pulse.
- setUCOE  out  1  overrun pulse.
- setUCBRK  out  1  break-detect pulse.
- RxBusy  out  1  a frame is in progress (UCBUSY).

## Operation
- Input synchronizer: Rx passes through a 2-FF synchronizer, giving rxs. All timing below refers to rxs.
- State IDLE:
  - A start is detected on the cycle rxs = 0 while the previous rxs = 1.
  - On start detection: latch wUCPEN, wUCPAR, wUCMSB, wUC7BIT and wUCSPB into shadow registers. Changes to these inputs later in the frame are ignored.
  - Clear the tick and bit counters, then go to START.
- Bit sampling:
  - The tick counter runs 0 … OVERSAMPLE−1 within each bit.
  - The sample point is C = OVERSAMPLE/2. The bit decision is registered at C+1 (majority build) or at C (single-sample build).
- State START:
  - Decision = 1: false start; return to IDLE with no pulses.
  - Decision = 0: go to DATA.
- State DATA:
  - 8 bits (7 if wUC7BIT).
  - LSB-first: shift right into the top bit of the field.
  - MSB-first: shift left into bit 0.
  - Then go to PARITY if wUCPEN, otherwise to STOP.
- State PARITY:
  - Mismatch between the received parity bit and the parity computed over the data bits sets an internal pe flag.
- State STOP:
  - Only the first stop bit is checked; wUCSPB does not extend reception.
  - Decision = 0 sets fe.
  - On the decision cycle:
    - RxBufWrite = setRXIFG = 1.
    - setUCFE = fe; setUCPE = pe.
    - setUCOE = RxBufFull.
    - setUCBRK = 1 when all data bits, the parity bit (if present) and the stop bit are 0.
  - The data is written even on overrun or error.
  - Next state is IDLE.
- After a break: IDLE requires a fresh 1→0 transition, so a held-low line does not retrigger.
- RxBusy = 1 in START, DATA, PARITY and STOP, including the write cycle. It is 0 in IDLE.
- Reset low, at any time including mid-frame: next edge enters IDLE, counters and shift register clear, synchronizer loads 1, and no pulse is generated.

## Timing
- Reset values: RxData = 0; RxBufWrite, setRXIFG, setUCFE, setUCPE, setUCOE, setUCBRK and RxBusy all 0.
- t0 = first cycle with rxs = 0. RxBusy rises at t0+1.
- Bit k (start = 0) has its decision at t0 + k·OVERSAMPLE + C + 1 in the majority build, or + C in the single-sample build.
- 8N1, OVERSAMPLE = 16, majority build: write strobe at t0+153; RxBusy falls at t0+154; a new start is accepted from t0+154.
- Pin-to-rxs latency is 2 cycles.
- All set* pulses are exactly one cycle wide and are never asserted outside the write cycle.

## Configuration
- UART_RX_MAJORITY_EN:
  - Defined: each bit decision is the 2-of-3 majority of samples at ticks C−1, C and C+1, registered at C+1. A single-tick glitch on the line is rejected.
  - Undefined: single sample at tick C, registered at C. All decisions move one cycle earlier. The majority logic is removed.

## Structure
- State encodings (IDLE, START, DATA, PARITY, STOP) and the default OVERSAMPLE go in the shared PARAMS.v include, next to the transmitter's constants.
- One sub-module, RxBitSampler, contains the synchronizer, tick counter and the majority/single-sample decision. It outputs a bit value and a one-cycle bitValid strobe.
- The FSM, shift register, parity accumulator and flag logic stay in receive_state_machine.

## Test plan
- 8N1, LSB-first, Rx drives 0xA5 → RxData = 0xA5; RxBufWrite and setRXIFG at t0+153; no error pulses.
- 7-bit, odd parity, 2 stop, MSB-first, Rx drives 0x35 with correct parity → RxData = 0x35. Repeat with the parity bit flipped → same data, setUCPE = 1.
- Stop bit driven 0 → setUCFE = 1 with data written. Then all-zero frame with Rx held low → setUCBRK = 1 and no retrigger until Rx returns high and falls again.
- RxBufFull = 1 at frame end → setUCOE = 1 and RxData updated. Start pulse shorter than C ticks → false start, RxBusy drops, no write.
- reset low at bit 4 of a frame → all outputs 0 on the next edge; the following clean 0x55 frame is received correctly.
- Majority build: a 1-tick glitch at tick C on a data bit → bit unaffected. Single-sample build: same stimulus → bit flips.
